// File: rtl/arith_pkg.sv
// Shared arithmetic-layer types for the scalar multiplier/divider pair.
// Sized constants stay as module parameters so each instance can choose its widths.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/scalar_division_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
// The requester drives the master side and the divider takes the slave side.
interface scalar_division_if #(
  parameter int ENTRY_SIZE    = 5,
  parameter int RESENTRY_SIZE = 9
);

  logic                     start;
  logic [RESENTRY_SIZE-1:0] dividend;
  logic [ENTRY_SIZE-1:0]    divisor;
  logic                     busy;
  logic                     done;
  logic [RESENTRY_SIZE-1:0] quotient;
  logic [ENTRY_SIZE-1:0]    remainder;
  logic                     div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/scalar_division_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int ENTRY_SIZE = 5
) (
  input  logic [ENTRY_SIZE:0]   p,
  input  logic                  in_bit,
  input  logic [ENTRY_SIZE-1:0] divisor,
  output logic [ENTRY_SIZE:0]   p_next,
  output logic                  q_bit
);

  logic [ENTRY_SIZE:0] p_shift;
  logic [ENTRY_SIZE:0] p_diff;
  logic                fits;

  // A set bit shifted out of P always means P' exceeds the divisor.
  assign p_shift = {p[ENTRY_SIZE-1:0], in_bit};
  assign p_diff  = p_shift - {1'b0, divisor};
  assign fits    = p[ENTRY_SIZE] | (p_shift >= {1'b0, divisor});

  always_comb begin
    p_next = p_shift;
    q_bit  = 1'b0;
    if (fits) begin
      p_next = p_diff;
      q_bit  = 1'b1;
    end
  end

endmodule

// File: rtl/scalar_division.sv
// Sequential unsigned restoring divider, one quotient bit per cycle behind a
// start/done handshake; latency is RESENTRY_SIZE edges regardless of operands.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one restoring iteration per cycle, counter RESENTRY_SIZE-1 down to 0
// DONE  | one-cycle done pulse; a start here is accepted immediately
module scalar_division
  import arith_pkg::*;
#(
  parameter int ENTRY_SIZE    = 5,
  parameter int RESENTRY_SIZE = 9
) (
  input  logic              clk,
  input  logic              reset,
  scalar_division_if.slave  bus
);

  localparam int CW = (RESENTRY_SIZE > 1) ? $clog2(RESENTRY_SIZE) : 1;

  div_state_t state, state_nxt;

  logic [CW-1:0]            cnt;
  logic [RESENTRY_SIZE-1:0] sr;
  logic [RESENTRY_SIZE-1:0] sr_next;
  logic [ENTRY_SIZE:0]      p;
  logic [ENTRY_SIZE:0]      p_step;
  logic [ENTRY_SIZE-1:0]    dsr;
  logic                     zero;
  logic                     q_bit;
  logic                     load;
  logic                     step;
  logic                     finish;

  div_step #(
    .ENTRY_SIZE (ENTRY_SIZE)
  ) u_step (
    .p       (p),
    .in_bit  (sr[RESENTRY_SIZE-1]),
    .divisor (dsr),
    .p_next  (p_step),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign sr_next = {sr[RESENTRY_SIZE-2:0], q_bit};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sr   <= '0;
      p    <= '0;
      dsr  <= '0;
      zero <= 1'b0;
    end else if (load) begin
      cnt  <= CW'(RESENTRY_SIZE - 1);
      sr   <= bus.dividend;
      p    <= '0;
      dsr  <= bus.divisor;
      zero <= (bus.divisor == '0);
    end else if (step) begin
      cnt  <= cnt - CW'(1);
      sr   <= sr_next;
      p    <= p_step;
    end
  end

  // Results are captured from the final iteration on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy <= (state_nxt == RUN);
      bus.done <= finish;
      if (finish) begin
        if (zero) begin
          bus.quotient    <= '1;
          bus.remainder   <= '0;
          bus.div_by_zero <= 1'b1;
        end else begin
          bus.quotient    <= sr_next;
          bus.remainder   <= p_step[ENTRY_SIZE-1:0];
          bus.div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/scalar_division.md
# scalar_division

Sequential unsigned divider, the inverse of the team's scalar multiplier: recovers quotient and remainder from a `RESENTRY_SIZE`-bit dividend (product-width value) and an `ENTRY_SIZE`-bit divisor (entry-width value). It uses a restoring, one-quotient-bit-per-cycle algorithm behind a start/done handshake. It sits beside the multiplier in the arithmetic layer, for normalising and averaging accumulated matrix results back to entry width.

## Interface
- `ENTRY_SIZE`, 5, width of divisor and remainder
- `RESENTRY_SIZE`, 9, width of dividend and quotient; must be ≥ `ENTRY_SIZE`

- `clk`  input  1  single clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high; sampled on rising edge of `clk`
- `start`  input  1  request; accepted only when `busy`=0
- `dividend`  input  `RESENTRY_SIZE`  numerator, sampled on accepting edge only
- `divisor`  input  `ENTRY_SIZE`  denominator, sampled on accepting edge only
- `busy`  output  1  high while a division is in flight
- `done`  output  1  one-cycle pulse, results valid
- `quotient`  output  `RESENTRY_SIZE`  dividend / divisor
- `remainder`  output  `ENTRY_SIZE`  dividend mod divisor
- `div_by_zero`  output  1  set with `done` when divisor was 0

## Operation
- States:
  - IDLE: `start`=1 → load and go to RUN; `busy`=1 from the next cycle.
  - RUN: performs `RESENTRY_SIZE` iterations, counted down from `RESENTRY_SIZE-1` to 0; at count 0 → DONE.
  - DONE: `done`=1 and `busy`=0 for exactly one cycle, then → IDLE. If `start`=1 in DONE, it is accepted and goes straight to RUN, giving back-to-back operation.
- Load:
  - Shift register takes `dividend`.
  - Partial remainder P (`ENTRY_SIZE+1` bits) is cleared.
  - Divisor register is loaded.
  - Zero flag = (`divisor`==0).
- Iteration:
  - P' = {P[ENTRY_SIZE-1:0], dividend MSB}, then shift the dividend register left.
  - If P' ≥ {0,divisor}: P = P' − divisor and shift in quotient bit 1.
  - Otherwise: P = P' and shift in 0.
- All arithmetic is unsigned. No truncation of the quotient can occur, because the quotient is `RESENTRY_SIZE` wide.
- Completion:
  - `quotient`, `remainder` and `div_by_zero` output registers update on the edge entering DONE.
  - They hold until the next completion, not the next start.
- Divide by zero:
  - Uses the same fixed latency.
  - Forced results: `quotient`=all ones, `remainder`=0, `div_by_zero`=1.
- `start` in RUN is ignored, with no queueing. Input changes during RUN have no effect.
- `reset` overrides everything, including mid-operation and a simultaneous `start`: state goes to IDLE and the in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE, counter 0.
- `start` is sampled at edge E.
- `busy`=1 from E through E+`RESENTRY_SIZE` (inclusive).
- `done`=1 after edge E+`RESENTRY_SIZE`, for one cycle. Latency is `RESENTRY_SIZE` edges (9 by default), data-independent.
- Throughput: one division per `RESENTRY_SIZE`+1 cycles if `start` waits for IDLE. One division per `RESENTRY_SIZE` cycles if `start` is presented during DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `arith_pkg`: state typedef `div_state_t` {IDLE, RUN, DONE}. Sized constants remain module parameters.
- One natural sub-module: `div_step`, a combinational single iteration.
  - Inputs: P, incoming bit, divisor.
  - Outputs: next P, quotient bit.
  - Instantiated once in the datapath.
- Counter width: $clog2(`RESENTRY_SIZE`).

## Test plan
- 255 / 5 → after 9 edges, `done` pulse; `quotient`=51, `remainder`=0, `div_by_zero`=0; `busy` high exactly 9 cycles.
- 200 / 7 → `quotient`=28, `remainder`=4. Then 3 / 31 → `quotient`=0, `remainder`=3. Then 511 / 1 → `quotient`=511, `remainder`=0.
- 100 / 0 → `done` after 9 edges; `quotient`=511, `remainder`=0, `div_by_zero`=1. The next valid division clears the flag.
- 200 / 7 started, then `start` with 50 / 5 at cycle 3 of RUN → ignored; result 28 r4; `done` pulses once.
- `start` 200 / 7 held in the DONE cycle of 255 / 5 → second `done` 9 edges later with 28 r4; first result (51 r0) stays stable in between.
- `reset` at cycle 4 of RUN → next cycle `busy`=0, all outputs 0, no `done`. A new 255 / 5 then completes normally with 51 r0.
